// File: rtl/spectrum_page_renderer.sv
// Renders a 32-bin spectrum frame into 512 OLED page bytes (4 pages x 128 columns,
// horizontal addressing) and streams them over a valid/ready handshake.
module spectrum_page_renderer #(
   parameter int unsigned NUM_BINS  = 32,
   parameter int unsigned MAG_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bin_wr_en,
   input  logic [4:0]           bin_wr_addr,
   input  logic [MAG_WIDTH-1:0] bin_wr_data,
   input  logic                 frame_commit,
   output logic [7:0]           byte_data,
   output logic                 byte_valid,
   input  logic                 byte_ready,
   output logic                 frame_start,
   output logic                 frame_done,
   output logic                 busy
);

   localparam int unsigned IDX_W   = 9;
   localparam int unsigned H_SHIFT = MAG_WIDTH - 5;

   typedef enum logic [1:0] {IDLE, LOAD, PRESENT} state_t;

   state_t                 state, state_nxt;
   logic [MAG_WIDTH-1:0]   bank [2][NUM_BINS];
   logic                   bank_sel;
   logic                   pending;
   logic [IDX_W-1:0]       idx;

   logic                   hs_c, last_c, swap_c;
   logic [4:0]             h_c;
   logic [7:0]             byte_c;
   logic [7:0]             byte_data_nxt;
   logic                   byte_valid_nxt, frame_start_nxt, frame_done_nxt, busy_nxt;

   // Row 8*page+k is lit when row + h reaches 32, i.e. row >= 32-h.
   always_comb begin
      h_c    = 5'(bank[bank_sel][idx[6:2]] >> H_SHIFT);
      byte_c = '0;
      for (int k = 0; k < 8; k++) begin
         byte_c[k] = (6'({idx[8:7], 3'(k)}) + 6'(h_c)) >= 6'd32;
      end
      if (idx[1:0] == 2'd3) begin
         byte_c = '0;
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         byte_data   <= '0;
         byte_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         byte_data   <= byte_data_nxt;
         byte_valid  <= byte_valid_nxt;
         frame_start <= frame_start_nxt;
         frame_done  <= frame_done_nxt;
         busy        <= busy_nxt;
      end
   end

   // Next-state logic; a commit coinciding with the last handshake chains the next frame.
   always_comb begin
      state_nxt = state;
      hs_c      = (state == PRESENT) && byte_ready;
      last_c    = hs_c && (idx == 9'd511);
      swap_c    = ((state == IDLE) && frame_commit) || (last_c && (pending || frame_commit));
      case (state)
         IDLE:    if (frame_commit) state_nxt = LOAD;
         LOAD:    state_nxt = PRESENT;
         PRESENT: begin
            if (last_c) begin
               state_nxt = swap_c ? LOAD : IDLE;
            end else if (hs_c) begin
               state_nxt = LOAD;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic feeding the output registers.
   always_comb begin
      byte_data_nxt   = byte_data;
      byte_valid_nxt  = (state_nxt == PRESENT);
      frame_start_nxt = (state_nxt == PRESENT) && (idx == '0);
      frame_done_nxt  = last_c;
      busy_nxt        = (state_nxt != IDLE);
      if (state == LOAD) begin
         byte_data_nxt = byte_c;
      end
   end

   // Bin banks, bank select, pending commit and byte index.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < int'(NUM_BINS); i++) begin
               bank[b][i] <= '0;
            end
         end
         bank_sel <= 1'b0;
         pending  <= 1'b0;
         idx      <= '0;
      end else begin
         if (bin_wr_en) begin
            bank[~bank_sel][bin_wr_addr] <= bin_wr_data;
         end
         if (swap_c) begin
            bank_sel <= ~bank_sel;
            pending  <= 1'b0;
         end else if (frame_commit && (state != IDLE)) begin
            pending  <= 1'b1;
         end
         if (hs_c) begin
            idx <= idx + 9'd1;
         end
      end
   end

endmodule

// File: tb/tb_spectrum_page_renderer.sv
// Directed bench for spectrum_page_renderer: frame streaming, bar shapes, stalls,
// pending commits and mid-frame reset, checked against a bar model.
module tb_spectrum_page_renderer;

   logic       clk = 1'b0;
   logic       rst;
   logic       bin_wr_en;
   logic [4:0] bin_wr_addr;
   logic [7:0] bin_wr_data;
   logic       frame_commit;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;
   logic       frame_start;
   logic       frame_done;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int d0;
   int h_cur [32];
   logic [7:0] got [512];

   spectrum_page_renderer #(.NUM_BINS(32), .MAG_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .bin_wr_en(bin_wr_en), .bin_wr_addr(bin_wr_addr), .bin_wr_data(bin_wr_data),
      .frame_commit(frame_commit),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] expb(input int i);
      int page, col, h;
      logic [7:0] b;
      page = i / 128;
      col  = i % 128;
      b    = 8'h00;
      if (col % 4 != 3) begin
         h = h_cur[col / 4];
         for (int k = 0; k < 8; k++) if (8 * page + k >= 32 - h) b[k] = 1'b1;
      end
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (byte_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic consume(input int i);
      wait_valid();
      chk($sformatf("valid_idx%0d", i), 32'(byte_valid), 32'd1);
      chk($sformatf("data_idx%0d", i), 32'(byte_data), 32'(expb(i)));
      chk($sformatf("start_idx%0d", i), 32'(frame_start), (i == 0) ? 32'd1 : 32'd0);
      got[i] = byte_data;
      byte_ready = 1'b1;
      @(posedge clk); #1;
      byte_ready = 1'b0;
   endtask

   task automatic frame(input int first, input int last);
      for (int i = first; i <= last; i++) consume(i);
   endtask

   task automatic write_bin(input logic [4:0] a, input logic [7:0] d);
      bin_wr_en = 1'b1; bin_wr_addr = a; bin_wr_data = d;
      @(posedge clk); #1;
      bin_wr_en = 1'b0;
   endtask

   task automatic commit();
      frame_commit = 1'b1;
      @(posedge clk); #1;
      frame_commit = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int b = 0; b < 32; b++) h_cur[b] = 0;
   endtask

   initial begin
      rst = 1'b1; bin_wr_en = 1'b0; bin_wr_addr = '0; bin_wr_data = '0;
      frame_commit = 1'b0; byte_ready = 1'b0;
      for (int b = 0; b < 32; b++) h_cur[b] = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", 32'(byte_data), 32'h00);
      chk("rst_valid", 32'(byte_valid), 32'd0);
      chk("rst_start", 32'(frame_start), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      // Empty frame: all zeros, latency and single frame_done
      commit();
      chk("t1_lat_valid0", 32'(byte_valid), 32'd0);
      chk("t1_busy_rise", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk("t1_lat_valid1", 32'(byte_valid), 32'd1);
      d0 = done_cnt;
      frame(0, 511);
      chk("t1_done_pulse", 32'(frame_done), 32'd1);
      chk("t1_busy_fall", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("t1_done_clear", 32'(frame_done), 32'd0);
      chk("t1_done_count", 32'(done_cnt - d0), 32'd1);

      // Full bar in bin 0 with a 20-cycle stall at idx 130
      do_reset();
      write_bin(5'd0, 8'hFF);
      h_cur[0] = 31;
      commit();
      frame(0, 129);
      wait_valid();
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         chk("t2_stall_valid", 32'(byte_valid), 32'd1);
         chk("t2_stall_data", 32'(byte_data), 32'hFF);
      end
      frame(130, 511);
      chk("t2_p0c0", 32'(got[0]), 32'hFE);
      chk("t2_p1c1", 32'(got[129]), 32'hFF);
      chk("t2_p3c2", 32'(got[386]), 32'hFF);
      chk("t2_p2c3", 32'(got[259]), 32'h00);
      chk("t2_p1c4", 32'(got[132]), 32'h00);

      // Partial bar in bin 5
      do_reset();
      write_bin(5'd5, 8'h50);
      h_cur[5] = 10;
      commit();
      frame(0, 511);
      chk("t3_p0c20", 32'(got[20]), 32'h00);
      chk("t3_p1c21", 32'(got[149]), 32'h00);
      chk("t3_p2c20", 32'(got[276]), 32'hC0);
      chk("t3_p3c22", 32'(got[406]), 32'hFF);
      chk("t3_p3c23", 32'(got[407]), 32'h00);
      chk("t3_p3c24", 32'(got[408]), 32'h00);

      // Write plus double commit mid-frame chains exactly one more frame
      do_reset();
      write_bin(5'd0, 8'hFF);
      h_cur[0] = 31;
      commit();
      d0 = done_cnt;
      frame(0, 199);
      wait_valid();
      bin_wr_en = 1'b1; bin_wr_addr = 5'd0; bin_wr_data = 8'h08; frame_commit = 1'b1;
      @(posedge clk); #1;
      bin_wr_en = 1'b0;
      @(posedge clk); #1;
      frame_commit = 1'b0;
      frame(200, 511);
      chk("t5_busy_held", 32'(busy), 32'd1);
      chk("t5_done1", 32'(frame_done), 32'd1);
      h_cur[0] = 1;
      @(posedge clk); #1;
      chk("t5_no_gap", 32'(byte_valid), 32'd1);
      frame(0, 511);
      chk("t5_p3c0", 32'(got[384]), 32'h80);
      chk("t5_p2c0", 32'(got[256]), 32'h00);
      @(posedge clk); #1;
      chk("t5_idle_busy", 32'(busy), 32'd0);
      chk("t5_done_count", 32'(done_cnt - d0), 32'd2);

      // Reset mid-frame with a pending commit
      do_reset();
      write_bin(5'd0, 8'hFF);
      h_cur[0] = 31;
      commit();
      frame(0, 249);
      commit();
      frame(250, 299);
      wait_valid();
      d0 = done_cnt;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int b = 0; b < 32; b++) h_cur[b] = 0;
      chk("t6_valid_low", 32'(byte_valid), 32'd0);
      chk("t6_busy_low", 32'(busy), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("t6_stay_idle", 32'(busy), 32'd0);
      chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
      commit();
      frame(0, 511);
      @(posedge clk); #1;
      chk("t6_done_count", 32'(done_cnt - d0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
